popcount_accum: RTL and testbench

POPCOUNT_ACCUM -- requirements
Module: popcount_accum

---
 rtl/popcount_pkg.sv | 21 ++
 rtl/popcount_tree.sv | 39 +++
 rtl/popcount_accum.sv | 150 +++++++++++++++
 tb/tb_popcount_accum.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// popcount_pkg -- shared types and helpers for the popcount accumulator.
//   mode_e  : MODE_WORD (one result per word) / MODE_FRAME (one sum per frame)
//   state_e : frame FSM states ST_IDLE / ST_ACC
//   count_w : minimum width that can hold a ones count of a data_w-bit word
package popcount_pkg;

  typedef enum logic {
    MODE_WORD  = 1'b0,
    MODE_FRAME = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  function automatic int count_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// popcount_tree -- combinational ones counter built as a recursive adder tree.
//   data  : input  [DATA_W-1:0]            word to count
//   count : output [count_w(DATA_W)-1:0]   number of set bits in data
// The word is split in halves, each half is counted by a smaller tree and the
// two partial counts are added, giving log2(DATA_W) adder levels.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]          data,
  output logic [count_w(DATA_W)-1:0] count
);

  localparam int CW = count_w(DATA_W);

  if (DATA_W == 1) begin : g_leaf
    assign count = data;
  end else begin : g_node
    localparam int LO_W = DATA_W / 2;
    localparam int HI_W = DATA_W - LO_W;

    logic [count_w(LO_W)-1:0] lo_count;
    logic [count_w(HI_W)-1:0] hi_count;

    popcount_tree #(.DATA_W(LO_W)) u_lo (
      .data  (data[LO_W-1:0]),
      .count (lo_count)
    );

    popcount_tree #(.DATA_W(HI_W)) u_hi (
      .data  (data[DATA_W-1:LO_W]),
      .count (hi_count)
    );

    assign count = CW'(lo_count) + CW'(hi_count);
  end

endmodule

// File: rtl/popcount_accum.sv
// popcount_accum -- two-stage ones counter with optional per-frame summation.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mode                     0 = WORD, 1 = FRAME (sampled on first word of a frame)
//   in_valid/in_ready        input handshake; in_ready = !out_valid || out_ready
//   in_data [DATA_W]         word to count
//   in_last                  last word of a frame (FRAME mode only)
//   out_valid/out_ready      output handshake
//   out_count [ACC_W]        word count or saturated frame sum
//   out_sat                  frame sum saturated
//   out_parity               XOR of all accepted bits of word/frame, present only
//                            when POPCOUNT_ACCUM_PARITY_EN is defined
// Stage S1 registers the popcount of an accepted word and the frame FSM;
// stage S2 folds it into the accumulator and loads the output register.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_count,
  output logic              out_sat
`ifdef POPCOUNT_ACCUM_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  localparam int CNT_W = count_w(DATA_W);

  logic             adv;
  logic             accept;
  mode_e            in_mode;
  logic [CNT_W-1:0] word_cnt;
  state_e           state;

  logic             s1_valid;
  logic             s1_first;  // word opens a new frame (or is a WORD-mode word)
  logic             s1_emit;   // word closes its frame and produces a result
  logic [CNT_W-1:0] s1_cnt;

  logic [ACC_W-1:0] acc;
  logic             acc_sat;
  logic [ACC_W-1:0] acc_base;
  logic             sat_base;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             sat_next;

  // Whole pipeline moves together; stalls only when a result is waiting.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign in_mode  = mode_e'(mode);

  popcount_tree #(.DATA_W(DATA_W)) u_tree (
    .data  (in_data),
    .count (word_cnt)
  );

  // S1 control and frame FSM. Mode is only looked at in ST_IDLE, so a mode
  // change in the middle of a frame has no effect.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_emit  <= 1'b0;
      state    <= ST_IDLE;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_first <= (state == ST_IDLE);
        s1_emit  <= (state == ST_IDLE && in_mode == MODE_WORD) || in_last;
        unique case (state)
          ST_IDLE: if (in_mode == MODE_FRAME && !in_last) state <= ST_ACC;
          ST_ACC:  if (in_last) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: datapath registers carry no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (accept) s1_cnt <= word_cnt;
  end

  // S2 arithmetic: restart from zero on a frame's first word, clamp on carry.
  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    acc_base = s1_first ? '0 : acc;
    sat_base = s1_first ? 1'b0 : acc_sat;
    sum      = {1'b0, acc_base} + (ACC_W + 1)'(s1_cnt);
    acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    sat_next = sat_base | sum[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      if (s1_valid) begin
        acc     <= acc_next;
        acc_sat <= sat_next;
      end
      out_valid <= s1_valid && s1_emit;
      if (s1_valid && s1_emit) begin
        out_count <= acc_next;
        out_sat   <= sat_next;
      end
    end
  end

`ifdef POPCOUNT_ACCUM_PARITY_EN
  logic s1_par;
  logic acc_par;
  logic par_next;

  always_ff @(posedge clk) begin
    if (accept) s1_par <= ^in_data;
  end

  assign par_next = s1_first ? s1_par : (acc_par ^ s1_par);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_par    <= 1'b0;
      out_parity <= 1'b0;
    end else if (adv && s1_valid) begin
      acc_par <= par_next;
      if (s1_emit) out_parity <= par_next;
    end
  end
`endif

endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum -- directed bench for popcount_accum.
// Two instances share the input stream: dut (DATA_W=32, ACC_W=16) and
// dut6 (DATA_W=32, ACC_W=6) which exercises frame-sum saturation.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_popcount_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  in_ready6;
  logic        out_valid, out_valid6;
  logic [15:0] out_count;
  logic [5:0]  out_count6;
  logic        out_sat,   out_sat6;
`ifdef POPCOUNT_ACCUM_PARITY_EN
  logic        out_parity, out_parity6;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  popcount_accum #(.DATA_W(32), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_sat   (out_sat)
`ifdef POPCOUNT_ACCUM_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  popcount_accum #(.DATA_W(32), .ACC_W(6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready6),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .out_count (out_count6),
    .out_sat   (out_sat6)
`ifdef POPCOUNT_ACCUM_PARITY_EN
    ,
    .out_parity(out_parity6)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic last, input logic m);
    in_valid = v;
    in_data  = d;
    in_last  = last;
    mode     = m;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset state
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_sat",   32'(out_sat),   32'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // WORD: 0xF0F0_0001 -> 9, two cycles after acceptance
    out_ready = 1'b1;
    drive(1'b1, 32'hF0F0_0001, 1'b0, 1'b0);
    tick();
    check("word_lat_early", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("word_valid", 32'(out_valid), 32'd1);
    check("word_count", 32'(out_count), 32'd9);
    check("word_sat",   32'(out_sat),   32'd0);
`ifdef POPCOUNT_ACCUM_PARITY_EN
    check("word_parity", 32'(out_parity), 32'd1);
`endif
    tick();
    check("word_single", 32'(out_valid), 32'd0);

    // WORD back-to-back: all-zero then all-ones
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    tick();
    check("b2b_early", 32'(out_valid), 32'd0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_count", 32'(out_count), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("ones_valid", 32'(out_valid), 32'd1);
    check("ones_count", 32'(out_count), 32'd32);
    tick();
    check("b2b_idle", 32'(out_valid), 32'd0);

    // FRAME: 0xFFFFFFFF, 0x3, 0x80000000(last) -> 35; mode dropped mid-frame
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check("frm_w1_noout", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    tick();
    check("frm_w2_noout", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b0);
    tick();
    check("frm_w3_noout", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("frm_valid",  32'(out_valid),  32'd1);
    check("frm_count",  32'(out_count),  32'd35);
    check("frm_sat",    32'(out_sat),    32'd0);
    check("frm6_count", 32'(out_count6), 32'd35);
    check("frm6_sat",   32'(out_sat6),   32'd0);
`ifdef POPCOUNT_ACCUM_PARITY_EN
    check("frm_parity", 32'(out_parity), 32'd1);
`endif
    tick();
    check("frm_single", 32'(out_valid), 32'd0);

    // Saturation: 3 x all-ones frame, then single-word frame, then a WORD word
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check("sat_w1_noout", 32'(out_valid), 32'd0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check("sat_w2_noout", 32'(out_valid), 32'd0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick();
    check("sat_w3_noout", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h0000_0001, 1'b1, 1'b1);
    tick();
    check("sat16_valid", 32'(out_valid),  32'd1);
    check("sat16_count", 32'(out_count),  32'd96);
    check("sat16_sat",   32'(out_sat),    32'd0);
    check("sat6_valid",  32'(out_valid6), 32'd1);
    check("sat6_count",  32'(out_count6), 32'd63);
    check("sat6_sat",    32'(out_sat6),   32'd1);
    drive(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    tick();
    check("one_frm_valid", 32'(out_valid),  32'd1);
    check("one_frm_count", 32'(out_count),  32'd1);
    check("clr6_count",    32'(out_count6), 32'd1);
    check("clr6_sat",      32'(out_sat6),   32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("after_frm_word_valid", 32'(out_valid), 32'd1);
    check("after_frm_word_count", 32'(out_count), 32'd2);
    check("after_frm_word_sat",   32'(out_sat),   32'd0);
    tick();
    check("sat_idle", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low for 5 cycles, words 0x1, 0x3, 0x7 offered
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    check("bp_ready_a", 32'(in_ready),  32'd1);
    check("bp_noout",   32'(out_valid), 32'd0);
    drive(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    tick();
    check("bp_a_valid",  32'(out_valid), 32'd1);
    check("bp_a_count",  32'(out_count), 32'd1);
    check("bp_ready_lo", 32'(in_ready),  32'd0);
`ifdef POPCOUNT_ACCUM_PARITY_EN
    check("bp_a_parity", 32'(out_parity), 32'd1);
`endif
    drive(1'b1, 32'h0000_0007, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_ready", 32'(in_ready),  32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_count", 32'(out_count), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_count", 32'(out_count), 32'd2);
`ifdef POPCOUNT_ACCUM_PARITY_EN
    check("bp_b_parity", 32'(out_parity), 32'd0);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("bp_c_valid", 32'(out_valid), 32'd1);
    check("bp_c_count", 32'(out_count), 32'd3);
`ifdef POPCOUNT_ACCUM_PARITY_EN
    check("bp_c_parity", 32'(out_parity), 32'd1);
`endif
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset mid-frame discards the partial frame
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check("rf_w1_noout", 32'(out_valid), 32'd0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check("rf_w2_noout", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rf_rst_valid", 32'(out_valid), 32'd0);
    check("rf_rst_count", 32'(out_count), 32'd0);
    tick();
    check("rf_ready",    32'(in_ready),  32'd1);
    check("rf_no_stale", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h0000_0001, 1'b1, 1'b1);
    tick();
    check("rf_early", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("rf_valid",  32'(out_valid),  32'd1);
    check("rf_count",  32'(out_count),  32'd1);
    check("rf_sat",    32'(out_sat),    32'd0);
    check("rf6_count", 32'(out_count6), 32'd1);
`ifdef POPCOUNT_ACCUM_PARITY_EN
    check("rf_parity", 32'(out_parity), 32'd1);
`endif
    tick();
    check("rf_single", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
